// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: issues one instruction-memory request at a time and
// tracks its response. It owns the IF/ID register and a one-entry skid buffer.
//
// state | meaning
// IDLE  | one cycle after reset release, no request
// REQ   | request driven on the bus, waiting for ready
// WAIT  | request accepted, waiting for the response
// HOLD  | response parked in the skid buffer while decode stalls
// FLUSH | stale request outstanding after a redirect, its response is dropped
module fetch_controller #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] pc_if,
  output logic        pc_enable,
  output logic        pc_sel_target,
  output logic [31:0] target_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FLUSH} state_t;

  state_t      state;
  logic [31:0] pending_pc;
  logic [31:0] skid_data;
  logic        skid_full;

  logic rsp_in_wait;
  logic consume_rsp;
  logic consume_skid;

  assign rsp_in_wait  = (state == WAIT) && imem_rsp_valid;
  assign consume_rsp  = rsp_in_wait && !stall_id && !redirect_valid;
  assign consume_skid = (state == HOLD) && skid_full && !stall_id && !redirect_valid;

  // Gated by rst so the PC and bus see quiet controls as soon as reset asserts.
  assign pc_enable      = rst && (redirect_valid || consume_rsp || consume_skid);
  assign pc_sel_target  = rst && redirect_valid;
  assign imem_req_valid = rst && (state == REQ);
  assign imem_req_addr  = pc_if;
  assign target_pc      = redirect_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pending_pc <= 32'h0;
      skid_data  <= NOP_INST;
      skid_full  <= 1'b0;
      inst_valid <= 1'b0;
      inst_data  <= NOP_INST;
      inst_pc    <= 32'h0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          // An unaccepted request is simply re-aimed; an accepted one must be drained.
          if (imem_req_ready) begin
            pending_pc <= pc_if;
            state      <= redirect_valid ? FLUSH : WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid)
            state <= (stall_id && !redirect_valid) ? HOLD : REQ;
          else if (redirect_valid)
            state <= FLUSH;
        end
        HOLD: begin
          if (redirect_valid || !stall_id)
            state <= REQ;
        end
        FLUSH: begin
          if (imem_rsp_valid)
            state <= REQ;
        end
        default: state <= IDLE;
      endcase

      if (redirect_valid) begin
        skid_full <= 1'b0;
      end else if (rsp_in_wait && stall_id) begin
        skid_full <= 1'b1;
        skid_data <= imem_rsp_data;
      end else if (consume_skid) begin
        skid_full <= 1'b0;
      end

      if (redirect_valid) begin
        inst_valid <= 1'b0;
        inst_data  <= NOP_INST;
      end else if (stall_id) begin
        inst_valid <= inst_valid;
      end else if (consume_rsp) begin
        inst_valid <= 1'b1;
        inst_data  <= imem_rsp_data;
        inst_pc    <= pending_pc;
      end else if (consume_skid) begin
        inst_valid <= 1'b1;
        inst_data  <= skid_data;
        inst_pc    <= pending_pc;
      end else begin
        inst_valid <= 1'b0;
        inst_data  <= NOP_INST;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: cycle vector table for the corner cases, an async
// reset sequence, then a randomized memory/stall stream against a scoreboard.
module tb_fetch_controller;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_id = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pc_if = 32'h0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        pc_enable, pc_sel_target, imem_req_valid, inst_valid;
  logic [31:0] target_pc, imem_req_addr, inst_data, inst_pc;

  fetch_controller #(.NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall_id(stall_id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc_if(pc_if),
    .pc_enable(pc_enable), .pc_sel_target(pc_sel_target), .target_pc(target_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] dd(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h5A00_0000 ^ (a << 4) ^ a;
  endfunction

  typedef struct {
    logic        r, s, x;
    logic [31:0] rpc, pc;
    logic        rdy, rv;
    logic [31:0] rd;
    logic        pe, sel, rq, iv;
    logic [31:0] idata, ipc;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, s, x, input logic [31:0] rpc, pc,
                     input logic rdy, rv, input logic [31:0] rd,
                     input logic pe, sel, rq, iv, input logic [31:0] idata, ipc);
    vec_t v;
    v.r = r; v.s = s; v.x = x; v.rpc = rpc; v.pc = pc; v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.pe = pe; v.sel = sel; v.rq = rq; v.iv = iv; v.idata = idata; v.ipc = ipc;
    vt.push_back(v);
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          k_acc, n_loaded, rsp_cnt;
  logic        load_pending;
  logic [31:0] model_pc, next_pc, out_addr;

  initial begin
    // r s x rpc pc rdy rv rd | pe sel rq iv idata ipc
    add(0,0,0,0,0,0,0,0,                    0,0,0,0,NOP,0);
    add(1,0,0,0,0,0,0,0,                    0,0,0,0,NOP,0);
    add(1,0,0,0,0,1,0,0,                    0,0,1,0,NOP,0);
    add(1,0,0,0,0,0,1,dd(0),                1,0,0,0,NOP,0);
    add(1,1,0,0,4,1,0,0,                    0,0,1,1,dd(0),0);
    add(1,1,0,0,4,0,1,dd(4),                0,0,0,1,dd(0),0);
    add(1,1,0,0,4,0,0,0,                    0,0,0,1,dd(0),0);
    add(1,1,0,0,4,1,0,0,                    0,0,0,1,dd(0),0);
    add(1,0,0,0,4,0,0,0,                    1,0,0,1,dd(0),0);
    add(1,0,0,0,8,0,0,0,                    0,0,1,1,dd(4),4);
    add(1,0,0,0,8,1,0,0,                    0,0,1,0,NOP,4);
    add(1,0,1,'h100,8,0,0,0,                1,1,0,0,NOP,4);
    add(1,0,0,0,'h100,0,0,0,                0,0,0,0,NOP,4);
    add(1,0,0,0,'h100,0,1,dd(8),            0,0,0,0,NOP,4);
    add(1,0,0,0,'h100,1,0,0,                0,0,1,0,NOP,4);
    add(1,0,0,0,'h100,0,1,dd('h100),        1,0,0,0,NOP,4);
    add(1,0,1,'h200,'h104,0,0,0,            1,1,1,1,dd('h100),'h100);
    add(1,0,0,0,'h200,1,0,0,                0,0,1,0,NOP,'h100);
    add(1,0,1,'h300,'h200,0,1,dd('h200),    1,1,0,0,NOP,'h100);
    add(1,0,0,0,'h300,1,0,0,                0,0,1,0,NOP,'h100);
    add(1,0,0,0,'h300,0,1,dd('h300),        1,0,0,0,NOP,'h100);
    add(1,1,0,0,'h304,1,0,0,                0,0,1,1,dd('h300),'h300);
    add(1,1,0,0,'h304,0,1,dd('h304),        0,0,0,1,dd('h300),'h300);
    add(1,1,1,'h400,'h304,0,0,0,            1,1,0,1,dd('h300),'h300);
    add(1,0,0,0,'h400,1,0,0,                0,0,1,0,NOP,'h300);
    add(1,0,0,0,'h400,0,1,dd('h400),        1,0,0,0,NOP,'h300);
    add(1,0,0,0,'h404,0,0,0,                0,0,1,1,dd('h400),'h400);
    add(1,1,0,0,'h404,0,0,0,                0,0,1,0,NOP,'h400);

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      rst = vt[i].r; stall_id = vt[i].s; redirect_valid = vt[i].x; redirect_pc = vt[i].rpc;
      pc_if = vt[i].pc; imem_req_ready = vt[i].rdy; imem_rsp_valid = vt[i].rv;
      imem_rsp_data = vt[i].rd;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {pc_enable, pc_sel_target, imem_req_valid, inst_valid, inst_data, inst_pc,
             imem_req_addr, target_pc},
            {vt[i].pe, vt[i].sel, vt[i].rq, vt[i].iv, vt[i].idata, vt[i].ipc,
             vt[i].pc, vt[i].rpc});
    end

    // Async reset in the middle of a WAIT cycle, then late responses after release.
    @(posedge clk); #1;
    stall_id = 0; redirect_valid = 0; redirect_pc = 0; pc_if = 'h404;
    imem_req_ready = 1; imem_rsp_valid = 0;
    @(posedge clk); #1;
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = dd('h404);
    @(negedge clk);
    check("wait_rsp_pc_enable", {159'h0, pc_enable}, 160'h1);
    @(posedge clk); #1;
    imem_rsp_valid = 0; pc_if = 'h408; imem_req_ready = 1;
    @(negedge clk);
    check("load_404", {inst_valid, inst_data, inst_pc}, {1'b1, dd('h404), 32'h404});
    @(posedge clk); #1;
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = dd('h408);
    #1;
    check("pre_reset_pc_enable", {159'h0, pc_enable}, 160'h1);
    #1 rst = 0;
    #1;
    check("async_reset_outputs",
          {pc_enable, pc_sel_target, imem_req_valid, inst_valid, inst_data, inst_pc},
          {4'b0000, NOP, 32'h0});
    imem_rsp_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1; pc_if = 0; imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("idle_after_release", {pc_enable, imem_req_valid, inst_valid}, 3'b000);
    @(posedge clk); #1;
    imem_rsp_valid = 1; imem_req_ready = 0;
    @(negedge clk);
    check("first_req_after_release", {imem_req_valid, imem_req_addr, inst_valid, pc_enable},
          {1'b1, 32'h0, 1'b0, 1'b0});
    @(posedge clk); #1;
    imem_rsp_valid = 0;
    @(negedge clk);
    check("late_rsp_ignored", {inst_valid, inst_data, imem_req_valid}, {1'b0, NOP, 1'b1});

    // Randomized stream: the bench owns the PC register and the memory model.
    @(posedge clk); #1;
    rst = 0; stall_id = 0; imem_req_ready = 0; imem_rsp_valid = 0; pc_if = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    k_acc = 0; n_loaded = 0; rsp_cnt = 0; load_pending = 0;
    model_pc = 0; next_pc = 0; out_addr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      model_pc = next_pc;
      pc_if = model_pc;
      imem_rsp_valid = 0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          imem_rsp_valid = 1;
          imem_rsp_data  = mem_word(out_addr);
        end
      end
      imem_req_ready = (cyc < 360) && ($urandom_range(1, 0) == 1);
      stall_id       = (cyc < 360) && ($urandom_range(3, 0) == 0);
      @(negedge clk);
      if (load_pending) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_load", {128'h0, inst_pc}, 160'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          n_loaded++;
          check("sb_load", {inst_valid, inst_pc, inst_data}, {1'b1, e.pc, e.data});
        end
      end
      load_pending = pc_enable && !pc_sel_target;
      if (pc_enable) next_pc = pc_sel_target ? target_pc : model_pc + 32'd4;
      if (imem_req_valid && imem_req_ready) begin
        check("sb_req_addr", {128'h0, imem_req_addr}, {128'h0, 32'(k_acc * 4)});
        out_addr = imem_req_addr;
        e.pc   = 32'(k_acc * 4);
        e.data = mem_word(32'(k_acc * 4));
        exp_q.push_back(e);
        k_acc++;
        rsp_cnt = $urandom_range(3, 1);
      end
    end
    check("sb_drained", {128'h0, 32'(exp_q.size())}, 160'h0);
    check("sb_enough_traffic", {159'h0, (n_loaded >= 20)}, 160'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the PC register of the standalone fetch stage against an external instruction-memory bus that uses a valid/ready request channel and a valid-only response channel.
- Drives the PC update enable and the redirect-target select.
- Keeps at most one request in flight.
- Discards stale responses after an EX redirect.
- Owns the IF/ID instruction register, with a one-entry skid buffer for decode stalls.

Parameters:
- NOP_INST, 32'h00000013, instruction word loaded into inst_data on reset and flush (bubble value).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- stall_id  in  1  decode stall; IF/ID register must hold.
- redirect_valid  in  1  one-cycle pulse from EX, taken branch/jump.
- redirect_pc  in  32  target address, valid with redirect_valid.
- pc_if  in  32  current PC from the fetch stage.
- pc_enable  out  1  PC flop update enable, 1 = load next PC.
- pc_sel_target  out  1  1 = next PC is target_pc, 0 = PC+4.
- target_pc  out  32  equals redirect_pc.
- imem_req_valid  out  1  fetch request.
- imem_req_addr  out  32  request address, equals pc_if.
- imem_req_ready  in  1  request accepted this cycle.
- imem_rsp_valid  in  1  response word valid.
- imem_rsp_data  in  32  response instruction.
- inst_valid  out  1  IF/ID valid.
- inst_data  out  32  IF/ID instruction.
- inst_pc  out  32  IF/ID PC.

Behaviour:
- Reset (rst=0, async): state=IDLE, inst_valid=0, inst_data=NOP_INST, inst_pc=0, skid empty, pending_pc=0. Combinational outputs pc_enable, pc_sel_target, imem_req_valid are 0.
- States: IDLE, REQ, WAIT, HOLD, FLUSH.
- IDLE: lasts one cycle after reset release, then goes to REQ.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc_if.
  - ready=1: latch pending_pc=pc_if, go to WAIT.
  - ready=0: stay in REQ.
- WAIT, imem_rsp_valid=1 and stall_id=0: load IF/ID with {1, rsp_data, pending_pc}, assert pc_enable (pc_sel_target=0), go to REQ.
- WAIT, imem_rsp_valid=1 and stall_id=1: store the response in the skid buffer, go to HOLD. PC is not advanced.
- HOLD: when stall_id=0, move the skid buffer into IF/ID, assert pc_enable, go to REQ.
- FLUSH: wait for imem_rsp_valid, drop the response, go to REQ. No PC update.
- IF/ID register:
  - With stall_id=1 it holds.
  - With stall_id=0 and no response or skid entry consumed this cycle, it loads a bubble: inst_valid=0, inst_data=NOP_INST. inst_pc holds.
- Latency: request acceptance to inst_valid is 1 edge after imem_rsp_valid. Back-to-back best case is 1 instruction per 2 cycles (REQ, WAIT), plus memory latency.
- pc_enable is a single-cycle pulse per consumed instruction or per redirect. It is never asserted in IDLE or FLUSH except on a redirect.
- Redirect priority: reset > redirect > stall_id > normal flow. On a redirect_valid cycle:
  - pc_enable=1, pc_sel_target=1.
  - IF/ID flushed (inst_valid=0, inst_data=NOP_INST) even if stall_id=1.
  - Skid buffer discarded.
- Next state after a redirect:
  - From IDLE or HOLD: go to REQ.
  - From REQ with ready=0: go to REQ. The unaccepted request is abortable, so the address changes to the new PC next cycle.
  - From REQ with ready=1: go to FLUSH, since the accepted request is stale.
  - From WAIT with rsp_valid=1: the response is dropped, go to REQ.
  - From WAIT with rsp_valid=0: go to FLUSH.
  - From FLUSH: stay in FLUSH. The outstanding response is still dropped.
- Bus contract: imem_req_valid/addr stay stable until ready, except on redirect. The controller never has more than one accepted, unanswered request.
- imem_rsp_valid outside WAIT/FLUSH is a protocol error and is ignored.
- Reset mid-operation: all state is dropped immediately. A response arriving after reset release, while in IDLE or REQ, is ignored.

Test Plan:
- Reset, then mem with ready=1 and response 1 cycle after accept; pc_if starts at 0. Expect requests at 0x0, 0x4, 0x8. Expect inst_valid pulses carrying inst_pc 0x0, 0x4, 0x8 with the matching data. Expect pc_enable once per instruction with pc_sel_target=0.
- Response for 0x4 arrives while stall_id=1 for 3 cycles. Expect IF/ID to hold the 0x0 instruction, state HOLD, no request and no pc_enable. On release, expect IF/ID=0x4 and the next request at 0x8.
- Redirect to 0x100 in WAIT with rsp_valid=0. Expect pc_enable=1, pc_sel_target=1, and inst_valid=0 next cycle. Expect the next response to be dropped, then a request at 0x100 and inst_pc 0x100 delivered.
- Redirect to 0x200 in REQ with ready=0. Expect imem_req_addr=0x200 next cycle and no FLUSH. Redirect in the same cycle as rsp_valid in WAIT: expect data dropped and IF/ID invalid.
- Redirect while stall_id=1 and HOLD is full. Expect IF/ID flushed to NOP_INST with inst_valid=0, skid discarded, and a request at the target.
- Assert rst=0 asynchronously mid-WAIT. Expect outputs to go to reset values immediately, without waiting for a clock edge. Expect a late rsp_valid after release to be ignored and the first request one cycle after release.
